// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared state encodings and address-field width helpers for
//               the direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fill  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;

    function automatic int offset_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Upper address bits left after word offset, line index and byte lane.
    function automatic int tag_w(input int lines, input int words);
        return 32 - 2 - $clog2(lines) - $clog2(words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Valid/tag/data storage with a combinational read port, a
//               single-word write port and a line-install port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array #(
    parameter int LINES    = 16,
    parameter int WORDS    = 4,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  i_rd_index,
    input  logic [OFFSET_W-1:0] i_rd_offset,
    output logic                o_rd_valid,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [31:0]         o_rd_word,
    input  logic                i_wr_en,
    input  logic [INDEX_W-1:0]  i_wr_index,
    input  logic [OFFSET_W-1:0] i_wr_offset,
    input  logic [31:0]         i_wr_data,
    input  logic                i_inst_en,
    input  logic [INDEX_W-1:0]  i_inst_index,
    input  logic [TAG_W-1:0]    i_inst_tag
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES*WORDS];

    logic [INDEX_W+OFFSET_W-1:0] w_rd_sel;
    logic [INDEX_W+OFFSET_W-1:0] w_wr_sel;

    assign w_rd_sel   = {i_rd_index, i_rd_offset};
    assign w_wr_sel   = {i_wr_index, i_wr_offset};
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_word  = r_data[w_rd_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i] <= '0;
            end
        end else if (i_inst_en) begin
            r_valid[i_inst_index] <= 1'b1;
            r_tag[i_inst_index]   <= i_inst_tag;
        end
    end

    // Data words need no reset: a line is only readable once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[w_wr_sel] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
// Module      : dcache_responder
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               between the MEM stage and a req/ack backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFFSET_W = offset_w(WORDS);
    localparam int INDEX_W  = index_w(LINES);
    localparam int TAG_W    = tag_w(LINES, WORDS);
    localparam logic [OFFSET_W-1:0] c_last_word = OFFSET_W'(WORDS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [OFFSET_W-1:0] r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_wr_hit;

    logic [OFFSET_W-1:0] w_offset;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W-1:0] w_req_offset;
    logic [INDEX_W-1:0]  w_req_index;
    logic [TAG_W-1:0]    w_req_tag;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [31:0]         w_line_word;
    logic                w_hit;
    logic                w_stall;
    logic                w_fill_we;
    logic                w_store_we;
    logic                w_install;
    logic                w_unused;

    assign w_offset     = addr[OFFSET_W+1:2];
    assign w_index      = addr[OFFSET_W+2 +: INDEX_W];
    assign w_tag        = addr[31 -: TAG_W];
    assign w_req_offset = r_mem_addr[OFFSET_W+1:2];
    assign w_req_index  = r_mem_addr[OFFSET_W+2 +: INDEX_W];
    assign w_req_tag    = r_mem_addr[31 -: TAG_W];
    assign w_unused     = ^{addr[1:0], r_mem_addr[1:0]};

    dcache_array #(
        .LINES    (LINES),
        .WORDS    (WORDS),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (reset),
        .i_rd_index   (w_index),
        .i_rd_offset  (w_offset),
        .o_rd_valid   (w_line_valid),
        .o_rd_tag     (w_line_tag),
        .o_rd_word    (w_line_word),
        .i_wr_en      (w_fill_we | w_store_we),
        .i_wr_index   (w_req_index),
        .i_wr_offset  (w_fill_we ? r_cnt : w_req_offset),
        .i_wr_data    (w_fill_we ? mem_rdata : r_mem_wdata),
        .i_inst_en    (w_install),
        .i_inst_index (w_req_index),
        .i_inst_tag   (w_req_tag)
    );

    assign w_hit     = w_line_valid && (w_line_tag == w_tag);
    assign rdata     = ((r_state == c_st_idle) && w_hit) ? w_line_word : 32'd0;
    assign stall     = w_stall;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_fill_we   = 1'b0;
        w_store_we  = 1'b0;
        w_install   = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Stores win over loads when both are presented.
                if (memwrite) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_st_write;
                end else if (memread && !w_hit) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_st_fill;
                end
            end
            c_st_fill: begin
                w_stall = 1'b1;
                if (mem_ack && r_mem_req) begin
                    w_fill_we = 1'b1;
                    if (r_cnt == c_last_word) begin
                        w_install   = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_write: begin
                w_stall = !(mem_ack && r_mem_req);
                if (mem_ack && r_mem_req) begin
                    w_store_we  = r_wr_hit;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_hit    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (memwrite) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {addr[31:2], 2'b00};
                        r_mem_wdata <= wdata;
                        r_wr_hit    <= w_hit;
                    end else if (memread && !w_hit) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {addr[31:OFFSET_W+2], {OFFSET_W{1'b0}}, 2'b00};
                        r_cnt      <= '0;
                    end
                end
                c_st_fill: begin
                    if (w_fill_we) begin
                        // Counter wraps back to zero on the final word.
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last_word) begin
                            r_mem_req <= 1'b0;
                        end else begin
                            r_mem_addr[OFFSET_W+1:2] <= r_cnt + 1'b1;
                        end
                    end
                end
                c_st_write: begin
                    if (mem_ack && r_mem_req) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder side of the pipeline's data-memory interface: accepts the MEM stage's addr/memread/memwrite/wdata requests and returns rdata.
- Direct-mapped, write-through, no-write-allocate cache, placed between the MEM stage and a slower backing memory.
- Backing memory uses a req/ack handshake.
- Asserts stall to freeze the pipeline on misses and while writes are in flight.

Parameters:
LINES, 16, number of cache lines; power of two, >=2
WORDS, 4, 32-bit words per line; power of two, >=2

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
addr  input  32  CPU byte address (bits [1:0] ignored)
memread  input  1  CPU load request
memwrite  input  1  CPU store request
wdata  input  32  CPU store data
rdata  output  32  load data; valid when memread=1 and stall=0
stall  output  1  hold pipeline; request is not complete
mem_req  output  1  backing-memory request, held until mem_ack
mem_we  output  1  1=write, 0=read; stable while mem_req=1
mem_addr  output  32  word-aligned backing address; stable while mem_req=1
mem_wdata  output  32  backing write data
mem_rdata  input  32  backing read data, valid with mem_ack
mem_ack  input  1  one-cycle completion pulse from backing memory

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (reset); every register, including storage valid bits, clears on reset.
- Address split: offset = addr[log2(WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- hit = valid[index] & (tag_store[index] == tag).
- Reset values:
  - state=IDLE, all valid bits=0, fill counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - stall=0 when no request is present; rdata=0 when state is not IDLE or there is no hit.
- States: IDLE, FILL, WRITE.
- IDLE:
  - memread & hit: rdata = line word (combinational), stall=0, zero added latency.
  - memread & ~hit: stall=1. Next state FILL; counter=0; mem_req=1, mem_we=0, mem_addr={tag,index,0,2'b00}.
  - memwrite: stall=1. Next state WRITE; mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00}, mem_wdata=wdata.
  - memwrite takes priority if both memread and memwrite are asserted.
  - No request: stall=0, mem_req=0.
- FILL:
  - stall=1 throughout.
  - On each mem_ack: write mem_rdata into the data word at the counter and increment the counter. mem_addr tracks the counter, keeping the request address's tag and index.
  - On the ack at counter=WORDS-1: set valid and tag; mem_req=0 next cycle; go to IDLE.
  - Next cycle the request hits and completes, so a read miss costs WORDS acks + 1 cycle.
- WRITE:
  - stall = ~mem_ack.
  - On mem_ack: if hit at entry, the cached word is updated with the write data in the same edge; mem_req drops; go to IDLE.
  - The pipeline advances on this cycle, so the store is never re-issued.
- The request inputs are sampled only in IDLE; they are held stable by stall during FILL/WRITE.
- mem_ack while mem_req=0 is ignored.
- Reset mid-FILL or mid-WRITE: abort at that edge; mem_req=0 next cycle; partial line discarded; all lines invalid.
- Counter wraps to 0 on fill completion.
- A store to a line that is not cached leaves the cache unchanged (no allocate).

Decomposition:
- Shared package dcache_pkg holds:
  - state encoding constants IDLE/FILL/WRITE;
  - localparam helpers for OFFSET_W, INDEX_W, TAG_W derived from LINES/WORDS.
- One natural sub-module, dcache_array:
  - holds valid/tag/data storage;
  - read port is combinational;
  - write ports: word write (data, index, offset) and line install (tag, valid);
  - clears valid on reset.
- The FSM and handshake stay in dcache_responder.

Test Plan:
- After reset, memread addr=0x40: stall=1; four mem_req reads at 0x40,0x44,0x48,0x4C, acked with data 0xA0..0xA3 (ack 2-cycle delayed). Required: stall drops the cycle after the last ack, with rdata=0xA0.
- Read 0x48 after that fill: stall=0 in the same cycle, rdata=0xA2, mem_req stays 0.
- memwrite addr=0x44 wdata=0xDEADBEEF (hit) with ack after 3 cycles: mem_we=1, mem_addr=0x44 held 3 cycles, stall low on the ack cycle. Then read 0x44 hits with rdata 0xDEADBEEF.
- memwrite to an uncached address 0x1000, then memread 0x1000: the write goes to memory, and the read causes a full fill (no allocate).
- Conflict: with LINES=16 and WORDS=4, read 0x40 then 0x440 (same index, new tag): the second read misses and refills; a re-read of 0x40 misses again.
- Assert reset for one cycle after the 2nd ack of a fill: mem_req=0 and stall=0 next cycle; a later read of the same address does a full 4-word fill.
